// File: rtl/ysyx_ifu_icache_pkg.sv
// Shared definitions for the IFU with direct-mapped L1 I-cache:
// FSM state encoding, default geometry and derived address-field widths.
package ysyx_ifu_icache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SETS       = 16;
    localparam int DEF_CNT_W      = 32;

    // Address = {tag, index, word offset, 2'b00}
    localparam int DEF_OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int DEF_IDX_W = $clog2(DEF_SETS);
    localparam int DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        VALID  = 2'd3
    } ifu_state_e;

    // Tag width left over once index, offset and byte bits are removed.
    function automatic int tag_width(int addr_w, int line_words, int sets);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/ysyx_ifu_icache_if.sv
// Pipeline handshake (PC in, instruction out), fence.i and instruction bus
// signals of the IFU. master = IFU side, slave = surrounding pipeline/bus.
interface ysyx_ifu_icache_if
    import ysyx_ifu_icache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              prev_valid;
    logic              ready_o;
    logic [ADDR_W-1:0] pc;
    logic              next_ready;
    logic              valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              flush;
    logic [ADDR_W-1:0] ifu_araddr_o;
    logic              ifu_arvalid_o;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rvalid;

    modport master (
        input  prev_valid, pc, next_ready, flush, ifu_rdata, ifu_rvalid,
        output ready_o, valid_o, inst_o, pc_o, ifu_araddr_o, ifu_arvalid_o
    );

    modport slave (
        output prev_valid, pc, next_ready, flush, ifu_rdata, ifu_rvalid,
        input  ready_o, valid_o, inst_o, pc_o, ifu_araddr_o, ifu_arvalid_o
    );
endinterface

// File: rtl/ysyx_icache_array.sv
// Tag/valid/data storage of the direct-mapped I-cache: one synchronous write
// port, combinational read, and a flush-all that clears every valid bit.
module ysyx_icache_array
    import ysyx_ifu_icache_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS,
    parameter int TAG_W      = DEF_TAG_W,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int IDX_W     = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              set_valid,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_vec;

    // Refill beat write into the data store, addressed by {set, word}
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_data;
    end

    // Tag is written once, together with the last beat of a refill
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[wr_idx] <= wr_tag;
    end

    // Per-set valid bit: reset and flush clear, completed refill sets
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        logic v_reg;
        always_ff @(posedge clk) begin
            if (!rst || flush)
                v_reg <= 1'b0;
            else if (set_valid && wr_idx == IDX_W'(gi))
                v_reg <= 1'b1;
        end
        assign valid_vec[gi] = v_reg;
    end

    assign rd_valid = valid_vec[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/ysyx_ifu_icache.sv
// Instruction fetch unit with a direct-mapped L1 I-cache. Accepts one PC,
// looks it up, refills a whole line word by word on a miss, then delivers
// one instruction with valid/ready backpressure. Counts hits and misses.
module ysyx_ifu_icache
    import ysyx_ifu_icache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_ifu_icache_if.master  bus,
    output logic [CNT_W-1:0]   hit_cnt_o,
    output logic [CNT_W-1:0]   miss_cnt_o
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, SETS);

    ifu_state_e        state_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic [OFF_W-1:0]  beat_reg;
    logic              refilled_reg;    // next LOOKUP is the post-refill one
    logic              flush_pend_reg;  // flush seen while refilling
    logic              valid_reg;
    logic              arvalid_reg;
    logic [ADDR_W-1:0] araddr_reg;
    logic [DATA_W-1:0] inst_reg;
    logic [ADDR_W-1:0] pc_out_reg;
    logic [CNT_W-1:0]  hit_cnt_reg;
    logic [CNT_W-1:0]  miss_cnt_reg;
    logic [DATA_W-1:0] line_buf [LINE_WORDS];

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  beat_next;
    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic              beat_fire;
    logic              last_beat;
    logic              hit;

    assign req_off   = req_pc_reg[OFF_W+1:2];
    assign req_idx   = req_pc_reg[OFF_W+2 +: IDX_W];
    assign req_tag   = req_pc_reg[ADDR_W-1 -: TAG_W];
    assign beat_next = beat_reg + OFF_W'(1);
    assign beat_fire = (state_reg == REFILL) && bus.ifu_rvalid;
    assign last_beat = beat_fire && (beat_reg == OFF_W'(LINE_WORDS - 1));
    assign hit       = arr_valid && (arr_tag == req_tag);

    ysyx_icache_array #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .wr_en     (beat_fire),
        .wr_idx    (req_idx),
        .wr_off    (beat_reg),
        .wr_data   (bus.ifu_rdata),
        .tag_we    (last_beat),
        .wr_tag    (req_tag),
        .set_valid (last_beat && !flush_pend_reg && !bus.flush),
        .rd_idx    (req_idx),
        .rd_off    (req_off),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data)
    );

    // Line buffer keeps the refilled words so a flushed refill can still deliver
    always_ff @(posedge clk) begin
        if (beat_fire) line_buf[beat_reg] <= bus.ifu_rdata;
    end

    // Fetch FSM with registered bus and pipeline outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            req_pc_reg     <= '0;
            beat_reg       <= '0;
            refilled_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            valid_reg      <= 1'b0;
            arvalid_reg    <= 1'b0;
            araddr_reg     <= '0;
            inst_reg       <= '0;
            pc_out_reg     <= '0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            if (bus.flush && state_reg == REFILL) flush_pend_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (bus.prev_valid) begin
                        req_pc_reg <= bus.pc;
                        state_reg  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (refilled_reg) begin
                        // Line just arrived: deliver without touching counters
                        inst_reg       <= flush_pend_reg ? line_buf[req_off] : arr_data;
                        pc_out_reg     <= req_pc_reg;
                        valid_reg      <= 1'b1;
                        refilled_reg   <= 1'b0;
                        flush_pend_reg <= 1'b0;
                        state_reg      <= VALID;
                    end else if (hit) begin
                        inst_reg    <= arr_data;
                        pc_out_reg  <= req_pc_reg;
                        valid_reg   <= 1'b1;
                        hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
                        state_reg   <= VALID;
                    end else begin
                        miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
                        beat_reg     <= '0;
                        arvalid_reg  <= 1'b1;
                        araddr_reg   <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                        state_reg    <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.ifu_rvalid) begin
                        if (last_beat) begin
                            arvalid_reg  <= 1'b0;
                            beat_reg     <= '0;
                            refilled_reg <= 1'b1;
                            state_reg    <= LOOKUP;
                        end else begin
                            beat_reg   <= beat_next;
                            araddr_reg <= {req_tag, req_idx, beat_next, 2'b00};
                        end
                    end
                end
                VALID: begin
                    if (bus.next_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready_o       = (state_reg == IDLE);
    assign bus.valid_o       = valid_reg;
    assign bus.inst_o        = inst_reg;
    assign bus.pc_o          = pc_out_reg;
    assign bus.ifu_araddr_o  = araddr_reg;
    assign bus.ifu_arvalid_o = arvalid_reg;
    assign hit_cnt_o         = hit_cnt_reg;
    assign miss_cnt_o        = miss_cnt_reg;

endmodule

// File: tb/tb_ysyx_ifu_icache.sv
// Randomised bench for ysyx_ifu_icache against a set-level cache model.
module tb_ysyx_ifu_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: which line each set holds, and the two counters
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int unsigned m_hit  = 0;
    int unsigned m_miss = 0;

    ysyx_ifu_icache_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ysyx_ifu_icache #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(16), .CNT_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9bdf ^ {a[15:0], a[31:16]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic flush_idle();
        bus_if.flush = 1'b1;
        clear_model();
        tick();
        bus_if.flush = 1'b0;
    endtask

    // One fetch: accept, serve the bus with random latency, check delivery,
    // optionally hold backpressure for `hold` cycles, then release.
    task automatic fetch(input logic [31:0] addr, input int flush_beat,
                         input bit flush_acc, input int hold);
        int          idx;
        int          beats;
        int          cyc;
        bit          hit;
        bit          pend;
        bit          prev_final;
        logic [31:0] tag;
        logic [31:0] base;
        logic [31:0] exp_inst;
        idx        = int'((addr / 16) % 16);
        tag        = addr / 256;
        base       = addr & ~32'hF;
        exp_inst   = mem_word(addr & ~32'h3);
        beats      = 0;
        cyc        = 0;
        pend       = 1'b0;
        prev_final = 1'b0;

        check_val("ready_idle", bus_if.ready_o, 1);
        if (flush_acc) clear_model();
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) m_hit++; else m_miss++;

        bus_if.pc         = addr;
        bus_if.prev_valid = 1'b1;
        bus_if.flush      = flush_acc;
        tick();
        bus_if.prev_valid = 1'b0;
        bus_if.flush      = 1'b0;
        check_val("lookup_no_valid", bus_if.valid_o, 0);

        while (!bus_if.valid_o && cyc < 200) begin
            bus_if.ifu_rvalid = 1'b0;
            bus_if.flush      = 1'b0;
            if (prev_final) check_val("arvalid_drop", bus_if.ifu_arvalid_o, 0);
            prev_final = 1'b0;
            if (bus_if.ifu_arvalid_o) begin
                check_val("araddr", bus_if.ifu_araddr_o, base + 32'(beats * 4));
                if (beats == flush_beat && !pend) begin
                    bus_if.flush = 1'b1;
                    pend = 1'b1;
                    clear_model();
                end
                if ($urandom_range(0, 2) != 0) begin
                    bus_if.ifu_rvalid = 1'b1;
                    bus_if.ifu_rdata  = mem_word(bus_if.ifu_araddr_o);
                    beats++;
                    prev_final = (beats == 4);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // stray response outside a refill must be ignored
                bus_if.ifu_rvalid = 1'b1;
                bus_if.ifu_rdata  = $urandom;
            end
            tick();
            cyc++;
        end
        bus_if.ifu_rvalid = 1'b0;
        bus_if.flush      = 1'b0;

        check_val("valid_seen", bus_if.valid_o, 1);
        check_val("beats", beats, hit ? 0 : 4);
        if (hit) check_val("hit_latency", cyc, 1);
        if (!hit) begin
            m_tag[idx]   = tag;
            m_valid[idx] = !pend;
        end
        check_val("inst", bus_if.inst_o, exp_inst);
        check_val("pc_o", bus_if.pc_o, addr);
        check_val("arvalid_valid", bus_if.ifu_arvalid_o, 0);
        check_val("hit_cnt", hit_cnt_o, m_hit);
        check_val("miss_cnt", miss_cnt_o, m_miss);
        $display("fetch pc=%h hit=%0d beats=%0d inst=%h flush_beat=%0d hold=%0d",
                 addr, hit, beats, bus_if.inst_o, flush_beat, hold);

        for (int k = 0; k < hold; k++) begin
            bus_if.next_ready = 1'b0;
            tick();
            check_val("bp_valid", bus_if.valid_o, 1);
            check_val("bp_inst", bus_if.inst_o, exp_inst);
            check_val("bp_pc", bus_if.pc_o, addr);
            check_val("bp_ready", bus_if.ready_o, 0);
        end
        bus_if.next_ready = 1'b1;
        tick();
        bus_if.next_ready = 1'b0;
        check_val("rel_valid", bus_if.valid_o, 0);
        check_val("rel_ready", bus_if.ready_o, 1);
    endtask

    // Start a miss, serve beats 0..2, then reset with a late rvalid around it
    task automatic reset_mid_refill(input logic [31:0] addr);
        int beats;
        int cyc;
        beats = 0;
        cyc   = 0;
        bus_if.pc         = addr;
        bus_if.prev_valid = 1'b1;
        tick();
        bus_if.prev_valid = 1'b0;
        while (beats < 3 && cyc < 50) begin
            bus_if.ifu_rvalid = 1'b0;
            if (bus_if.ifu_arvalid_o) begin
                bus_if.ifu_rvalid = 1'b1;
                bus_if.ifu_rdata  = mem_word(bus_if.ifu_araddr_o);
                beats++;
            end
            tick();
            cyc++;
        end
        check_val("rst_beats", beats, 3);
        rst               = 1'b0;
        bus_if.ifu_rvalid = 1'b1;
        bus_if.ifu_rdata  = mem_word(addr | 32'hC);
        tick();
        rst = 1'b1;
        clear_model();
        m_hit  = 0;
        m_miss = 0;
        check_val("rst_arvalid", bus_if.ifu_arvalid_o, 0);
        check_val("rst_valid", bus_if.valid_o, 0);
        check_val("rst_hit", hit_cnt_o, 0);
        check_val("rst_miss", miss_cnt_o, 0);
        check_val("rst_ready", bus_if.ready_o, 1);
        tick();
        bus_if.ifu_rvalid = 1'b0;
        check_val("late_rvalid_arvalid", bus_if.ifu_arvalid_o, 0);
        check_val("late_rvalid_ready", bus_if.ready_o, 1);
        $display("reset mid-refill pc=%h after %0d beats", addr, beats);
    endtask

    initial begin
        bus_if.prev_valid = 1'b0;
        bus_if.pc         = '0;
        bus_if.next_ready = 1'b0;
        bus_if.flush      = 1'b0;
        bus_if.ifu_rdata  = '0;
        bus_if.ifu_rvalid = 1'b0;
        clear_model();
        tick();
        tick();
        rst = 1'b1;
        check_val("reset_ready", bus_if.ready_o, 1);
        check_val("reset_valid", bus_if.valid_o, 0);
        check_val("reset_arvalid", bus_if.ifu_arvalid_o, 0);
        check_val("reset_araddr", bus_if.ifu_araddr_o, 0);
        check_val("reset_inst", bus_if.inst_o, 0);
        check_val("reset_pc_o", bus_if.pc_o, 0);
        check_val("reset_hit", hit_cnt_o, 0);
        check_val("reset_miss", miss_cnt_o, 0);

        // cold miss, same-line hit, conflict eviction
        fetch(32'h8000_0000, -1, 1'b0, 0);
        fetch(32'h8000_0008, -1, 1'b0, 0);
        fetch(32'h8000_0100, -1, 1'b0, 0);
        fetch(32'h8000_0000, -1, 1'b0, 0);
        check_val("conflict_miss3", miss_cnt_o, 3);

        // flush in idle, then flush during beat 1, then flush with accept
        fetch(32'h8000_0008, -1, 1'b0, 0);
        flush_idle();
        fetch(32'h8000_0008, -1, 1'b0, 0);
        fetch(32'h8000_0204,  1, 1'b0, 0);
        fetch(32'h8000_0204, -1, 1'b0, 0);
        fetch(32'h8000_0008, -1, 1'b1, 0);

        // backpressure on a hit
        fetch(32'h8000_0008, -1, 1'b0, 5);

        // reset in the middle of a refill, then full refetch
        reset_mid_refill(32'h8000_0010);
        fetch(32'h8000_0010, -1, 1'b0, 0);

        // random traffic over a few aliasing lines
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          fb;
            a  = 32'h8000_0000 + 32'($urandom_range(0, 2) * 256) + 32'($urandom_range(0, 63) * 4);
            fb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 9) == 0) flush_idle();
            fetch(a, fb, $urandom_range(0, 9) == 0, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
